// File: rtl/ft_frame_sequencer.sv
// Frame-level fingertip sequencer: tracks the leftmost skin pixel over one frame and publishes it.
// Optional build macro FT_SMOOTH_EN averages each found position with the previous published one.
`timescale 1ns/1ps
module ft_frame_sequencer #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned MIN_PIXELS    = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDCLEAN,
  input  logic        iDVAL,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iFrame_En,
  input  logic        iREADY,
  output logic [9:0]  oFT_X,
  output logic [9:0]  oFT_Y,
  output logic        oFT_FOUND,
  output logic        oDVAL,
  output logic        oBUSY,
  output logic [7:0]  oDROP_CNT
);

  localparam logic [15:0] XLast   = 16'(2 * SCREEN_WIDTH - 1);
  localparam logic [15:0] YLast   = 16'(2 * SCREEN_HEIGHT - 1);
  localparam logic [15:0] MinSkin = 16'(MIN_PIXELS);

  typedef enum logic [1:0] {StIdle, StWaitSof, StScan, StPublish} state_t;

  state_t      state;
  logic [14:0] minX;
  logic [14:0] yOfMin;
  logic [15:0] skinCnt;

  logic        sof;
  logic        eof;
  logic        skin;
  logic [14:0] pixX;
  logic [14:0] pixY;
  logic [14:0] baseX;
  logic [15:0] baseCnt;
  logic [14:0] nxtX;
  logic [14:0] nxtY;
  logic [15:0] nxtCnt;
  logic        found;
  logic [9:0]  rawX;
  logic [9:0]  rawY;
  logic [9:0]  pubX;
  logic [9:0]  pubY;

`ifdef FT_SMOOTH_EN
  logic [9:0]  prevX;
  logic [9:0]  prevY;
  logic        histValid;
  logic [10:0] sumX;
  logic [10:0] sumY;
`endif

  assign pixX  = iX_Cont[15:1];
  assign pixY  = iY_Cont[15:1];
  assign sof   = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign eof   = iDVAL && (iX_Cont == XLast) && (iY_Cont == YLast);
  assign skin  = iDVAL && iDCLEAN;
  assign oBUSY = (state == StScan);

  // Tracker after the current pixel; a SOF clears it before the SOF pixel is evaluated.
  always_comb begin
    baseX   = sof ? 15'h7FFF : minX;
    baseCnt = sof ? 16'd0 : skinCnt;
    nxtX    = baseX;
    nxtY    = yOfMin;
    nxtCnt  = baseCnt;
    if (skin) begin
      if (baseCnt != 16'hFFFF) nxtCnt = baseCnt + 16'd1;
      if (pixX < baseX) begin
        nxtX = pixX;
        nxtY = pixY;
      end
    end
  end

  always_comb begin
    found = (nxtCnt >= MinSkin);
    rawX  = (nxtX == 15'h7FFF) ? 10'd0 : nxtX[9:0];
    rawY  = (nxtX == 15'h7FFF) ? 10'd0 : nxtY[9:0];
`ifdef FT_SMOOTH_EN
    sumX = {1'b0, prevX} + {1'b0, rawX};
    sumY = {1'b0, prevY} + {1'b0, rawY};
    if (!found) begin
      pubX = 10'd0;
      pubY = 10'd0;
    end else if (histValid) begin
      pubX = 10'(sumX >> 1);
      pubY = 10'(sumY >> 1);
    end else begin
      pubX = rawX;
      pubY = rawY;
    end
`else
    pubX = rawX;
    pubY = rawY;
`endif
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= StIdle;
      minX      <= 15'h7FFF;
      yOfMin    <= 15'd0;
      skinCnt   <= 16'd0;
      oFT_X     <= 10'd0;
      oFT_Y     <= 10'd0;
      oFT_FOUND <= 1'b0;
      oDVAL     <= 1'b0;
      oDROP_CNT <= 8'd0;
`ifdef FT_SMOOTH_EN
      prevX     <= 10'd0;
      prevY     <= 10'd0;
      histValid <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (iFrame_En) state <= StWaitSof;
        end
        StWaitSof: begin
          if (!iFrame_En) begin
            state <= StIdle;
          end else if (sof) begin
            state   <= StScan;
            minX    <= nxtX;
            yOfMin  <= nxtY;
            skinCnt <= nxtCnt;
          end
        end
        StScan: begin
          // Disarming mid-frame does not abort; the frame always completes.
          minX    <= nxtX;
          yOfMin  <= nxtY;
          skinCnt <= nxtCnt;
          if (eof) begin
            state     <= StPublish;
            oFT_X     <= pubX;
            oFT_Y     <= pubY;
            oFT_FOUND <= found;
            oDVAL     <= 1'b1;
`ifdef FT_SMOOTH_EN
            if (found) begin
              prevX     <= pubX;
              prevY     <= pubY;
              histValid <= 1'b1;
            end else begin
              histValid <= 1'b0;
            end
`endif
          end
        end
        StPublish: begin
          if (iREADY) begin
            oDVAL <= 1'b0;
            state <= iFrame_En ? StWaitSof : StIdle;
          end else if (sof && (oDROP_CNT != 8'hFF)) begin
            oDROP_CNT <= oDROP_CNT + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
